// File: rtl/ifm_rx_ingress.sv
// MAC receive ingress: writes whole frames to the data FIFO and one {len, status} word per frame
// to the info FIFO, with post-reset resync, oversize/runt flags, overflow drop/truncate or backpressure.
module ifm_rx_ingress #(
  parameter int unsigned C_DATA_WIDTH   = 64,
  parameter int unsigned C_KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int unsigned C_LEN_WIDTH    = 16,
  parameter int unsigned C_MAX_FRAME    = 9216,
  parameter int unsigned C_MIN_FRAME    = 64,
  parameter int unsigned C_BACKPRESSURE = 0
) (
  input  logic                                       rx_clk,
  input  logic                                       rx_reset,
  input  logic [C_DATA_WIDTH-1:0]                    rx_axis_mac_tdata,
  input  logic [C_KEEP_WIDTH-1:0]                    rx_axis_mac_tkeep,
  input  logic                                       rx_axis_mac_tlast,
  input  logic                                       rx_axis_mac_tuser,
  input  logic                                       rx_axis_mac_tvalid,
  output logic                                       rx_axis_mac_tready,
  output logic [C_DATA_WIDTH+C_KEEP_WIDTH:0]         data_fifo_wdata,
  output logic                                       data_fifo_wren,
  input  logic                                       data_fifo_afull,
  output logic [C_LEN_WIDTH+7:0]                     info_fifo_wdata,
  output logic                                       info_fifo_wren,
  input  logic                                       info_fifo_afull,
  output logic [31:0]                                drop_cnt,
  output logic [31:0]                                err_cnt,
  output logic [3:0]                                 ifm_in_fsm_dbg
);

  localparam int unsigned DW_W   = C_DATA_WIDTH + C_KEEP_WIDTH + 1;
  localparam int unsigned IW_W   = C_LEN_WIDTH + 8;
  localparam int unsigned LEN1_W = C_LEN_WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(C_KEEP_WIDTH + 1);
  localparam bit          BP     = (C_BACKPRESSURE != 0);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_IDLE  = 3'd1,
    S_PASS  = 3'd2,
    S_DROP  = 3'd3,
    S_TRUNC = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [C_LEN_WIDTH-1:0]  len_q, len_d;
  logic [DW_W-1:0]         dwdata_q, dwdata_d;
  logic                    dwren_q, dwren_d;
  logic [IW_W-1:0]         iwdata_q, iwdata_d;
  logic                    iwren_q, iwren_d;
  logic [31:0]             drop_cnt_q, drop_cnt_d;
  logic [31:0]             err_cnt_q, err_cnt_d;

  logic                    afull_c;
  logic                    tready_c;
  logic                    acc_c;
  logic [CNT_W-1:0]        bytes_c;
  logic [LEN1_W-1:0]       sum_c;
  logic [C_LEN_WIDTH-1:0]  len_next_c;
  logic                    over_c;
  logic                    runt_c;
  logic [7:0]              st_end_c;
  logic [DW_W-1:0]         beat_c;

  assign afull_c = data_fifo_afull | info_fifo_afull;

  // Backpressure only ever stalls a frame start (any afull) or a frame body (data afull).
  always_comb begin
    tready_c = 1'b1;
    if (BP) begin
      if (state_q == S_IDLE) begin
        tready_c = ~afull_c;
      end else if (state_q == S_PASS) begin
        tready_c = ~data_fifo_afull;
      end
    end
  end

  assign acc_c = rx_axis_mac_tvalid & tready_c;

  always_comb begin
    bytes_c = '0;
    for (int i = 0; i < int'(C_KEEP_WIDTH); i++) begin
      bytes_c = bytes_c + CNT_W'(rx_axis_mac_tkeep[i]);
    end
  end

  // Running length saturates at all-ones; a frame start restarts it from this beat.
  assign sum_c      = {1'b0, len_q} + LEN1_W'(bytes_c);
  assign len_next_c = (state_q == S_IDLE) ? C_LEN_WIDTH'(bytes_c)
                    : (sum_c[C_LEN_WIDTH] ? '1 : sum_c[C_LEN_WIDTH-1:0]);
  assign over_c     = 32'(len_next_c) > 32'(C_MAX_FRAME);
  assign runt_c     = 32'(len_next_c) < 32'(C_MIN_FRAME);
  assign st_end_c   = {4'b0000, runt_c, over_c, 1'b0, rx_axis_mac_tuser};
  assign beat_c     = {rx_axis_mac_tlast, rx_axis_mac_tkeep, rx_axis_mac_tdata};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    dwdata_d   = dwdata_q;
    dwren_d    = 1'b0;
    iwdata_d   = iwdata_q;
    iwren_d    = 1'b0;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      S_SYNC: begin
        if (acc_c && rx_axis_mac_tlast) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (acc_c) begin
          len_d = len_next_c;
          if (!BP && afull_c) begin
            drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 32'd1;
            if (!rx_axis_mac_tlast) state_d = S_DROP;
          end else begin
            dwren_d  = 1'b1;
            dwdata_d = beat_c;
            if (rx_axis_mac_tlast) begin
              iwren_d  = 1'b1;
              iwdata_d = {len_next_c, st_end_c};
            end else begin
              state_d = S_PASS;
            end
          end
        end
      end
      S_PASS: begin
        if (acc_c) begin
          len_d    = len_next_c;
          dwren_d  = 1'b1;
          dwdata_d = beat_c;
          if (rx_axis_mac_tlast) begin
            iwren_d  = 1'b1;
            iwdata_d = {len_next_c, st_end_c};
            state_d  = S_IDLE;
          end else if (over_c) begin
            dwdata_d[DW_W-1] = 1'b1;
            iwren_d          = 1'b1;
            iwdata_d         = {len_next_c, 8'h04};
            state_d          = S_TRUNC;
          end else if (!BP && data_fifo_afull) begin
            dwdata_d[DW_W-1] = 1'b1;
            iwren_d          = 1'b1;
            iwdata_d         = {len_next_c, 8'h02};
            state_d          = S_TRUNC;
          end
        end
      end
      S_DROP, S_TRUNC: begin
        if (acc_c && rx_axis_mac_tlast) state_d = S_IDLE;
      end
      default: state_d = S_SYNC;
    endcase
    if (iwren_d && (iwdata_d[7:0] != 8'h00)) begin
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge rx_clk or posedge rx_reset) begin
    if (rx_reset) begin
      state_q    <= S_SYNC;
      len_q      <= '0;
      dwdata_q   <= '0;
      dwren_q    <= 1'b0;
      iwdata_q   <= '0;
      iwren_q    <= 1'b0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      dwdata_q   <= dwdata_d;
      dwren_q    <= dwren_d;
      iwdata_q   <= iwdata_d;
      iwren_q    <= iwren_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign rx_axis_mac_tready = tready_c;
  assign data_fifo_wdata    = dwdata_q;
  assign data_fifo_wren     = dwren_q;
  assign info_fifo_wdata    = iwdata_q;
  assign info_fifo_wren     = iwren_q;
  assign drop_cnt           = drop_cnt_q;
  assign err_cnt            = err_cnt_q;
  assign ifm_in_fsm_dbg     = {1'b0, state_q};

endmodule

// File: tb/tb_ifm_rx_ingress.sv
// Bench for ifm_rx_ingress: directed frames plus random traffic on a drop-mode and a
// backpressure-mode instance, scored cycle by cycle against a frame-rule reference model.
module tb_ifm_rx_ingress;

  logic        rx_clk = 1'b0;
  logic        rx_reset = 1'b1;
  logic [63:0] tdata [2];
  logic [7:0]  tkeep [2];
  logic        tlast [2];
  logic        tuser [2];
  logic        tvalid [2];
  logic        tready [2];
  logic [72:0] dwd [2];
  logic        dwren [2];
  logic        dafull [2];
  logic [23:0] iwd [2];
  logic        iwren [2];
  logic        iafull [2];
  logic [31:0] dropc [2];
  logic [31:0] errc [2];
  logic [3:0]  dbg [2];

  int n_cmp = 0;
  int n_err = 0;
  bit rand_af = 1'b0;

  // Reference-model state per instance
  bit          m_sync [2];
  bit          m_infr [2];
  bit          m_disc [2];
  int          m_len [2];
  logic [31:0] m_drop [2];
  logic [31:0] m_err [2];
  bit          e_dwr [2];
  bit          e_iwr [2];
  logic [72:0] e_dwd [2];
  logic [23:0] e_iwd [2];
  bit          acc_seen [2];
  // Observed-write bookkeeping for the directed checks
  int          dwr_n [2];
  int          iwr_n [2];
  logic [72:0] last_dwd [2];
  logic [23:0] last_iwd [2];

  always #5 rx_clk = ~rx_clk;

  ifm_rx_ingress #(.C_MAX_FRAME(128), .C_BACKPRESSURE(0)) dut0 (
    .rx_clk(rx_clk), .rx_reset(rx_reset),
    .rx_axis_mac_tdata(tdata[0]), .rx_axis_mac_tkeep(tkeep[0]), .rx_axis_mac_tlast(tlast[0]),
    .rx_axis_mac_tuser(tuser[0]), .rx_axis_mac_tvalid(tvalid[0]), .rx_axis_mac_tready(tready[0]),
    .data_fifo_wdata(dwd[0]), .data_fifo_wren(dwren[0]), .data_fifo_afull(dafull[0]),
    .info_fifo_wdata(iwd[0]), .info_fifo_wren(iwren[0]), .info_fifo_afull(iafull[0]),
    .drop_cnt(dropc[0]), .err_cnt(errc[0]), .ifm_in_fsm_dbg(dbg[0]));

  ifm_rx_ingress #(.C_BACKPRESSURE(1)) dut1 (
    .rx_clk(rx_clk), .rx_reset(rx_reset),
    .rx_axis_mac_tdata(tdata[1]), .rx_axis_mac_tkeep(tkeep[1]), .rx_axis_mac_tlast(tlast[1]),
    .rx_axis_mac_tuser(tuser[1]), .rx_axis_mac_tvalid(tvalid[1]), .rx_axis_mac_tready(tready[1]),
    .data_fifo_wdata(dwd[1]), .data_fifo_wren(dwren[1]), .data_fifo_afull(dafull[1]),
    .info_fifo_wdata(iwd[1]), .info_fifo_wren(iwren[1]), .info_fifo_afull(iafull[1]),
    .drop_cnt(dropc[1]), .err_cnt(errc[1]), .ifm_in_fsm_dbg(dbg[1]));

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_bp(input int k);
    return k == 1;
  endfunction

  function automatic int max_frame(input int k);
    return (k == 0) ? 128 : 9216;
  endfunction

  function automatic logic [31:0] bump(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit model_ready(input int k);
    if (!is_bp(k) || !m_sync[k] || m_disc[k]) return 1'b1;
    if (!m_infr[k]) return !(dafull[k] || iafull[k]);
    return !dafull[k];
  endfunction

  task automatic put_info(input int k, input logic [7:0] st);
    e_iwr[k] = 1'b1;
    e_iwd[k] = {16'(m_len[k]), st};
    if (st != 8'h00) m_err[k] = bump(m_err[k]);
  endtask

  // Frame-level rules applied to one accepted beat
  task automatic model_beat(input int k);
    logic [72:0] beat;
    int b;
    bit bad;
    beat = {tlast[k], tkeep[k], tdata[k]};
    b = $countones(tkeep[k]);
    bad = tuser[k];
    if (!m_sync[k]) begin
      if (tlast[k]) m_sync[k] = 1'b1;
    end else if (m_disc[k]) begin
      if (tlast[k]) m_disc[k] = 1'b0;
    end else if (!m_infr[k]) begin
      if (!is_bp(k) && (dafull[k] || iafull[k])) begin
        m_drop[k] = bump(m_drop[k]);
        if (!tlast[k]) m_disc[k] = 1'b1;
      end else begin
        m_len[k] = b;
        e_dwr[k] = 1'b1; e_dwd[k] = beat;
        if (tlast[k]) put_info(k, {4'h0, m_len[k] < 64, m_len[k] > max_frame(k), 1'b0, bad});
        else m_infr[k] = 1'b1;
      end
    end else begin
      m_len[k] = (m_len[k] + b > 65535) ? 65535 : m_len[k] + b;
      e_dwr[k] = 1'b1; e_dwd[k] = beat;
      if (tlast[k]) begin
        put_info(k, {4'h0, m_len[k] < 64, m_len[k] > max_frame(k), 1'b0, bad});
        m_infr[k] = 1'b0;
      end else if (m_len[k] > max_frame(k) || (!is_bp(k) && dafull[k])) begin
        e_dwd[k][72] = 1'b1;
        put_info(k, (m_len[k] > max_frame(k)) ? 8'h04 : 8'h02);
        m_infr[k] = 1'b0; m_disc[k] = 1'b1;
      end
    end
  endtask

  // Model step on every edge, then compare all registered outputs just after it
  always @(posedge rx_clk) begin
    for (int k = 0; k < 2; k++) begin
      e_dwr[k] = 1'b0; e_iwr[k] = 1'b0; acc_seen[k] = 1'b0;
      if (rx_reset) begin
        m_sync[k] = 1'b0; m_infr[k] = 1'b0; m_disc[k] = 1'b0; m_len[k] = 0;
        m_drop[k] = '0; m_err[k] = '0; e_dwd[k] = '0; e_iwd[k] = '0;
        if (!is_bp(k)) chk("tready_in_reset", tready[k], 1'b1);
      end else begin
        chk("tready", tready[k], model_ready(k));
        if (tvalid[k] && model_ready(k)) begin
          acc_seen[k] = 1'b1;
          model_beat(k);
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("data_wren", dwren[k], e_dwr[k]);
      chk("data_wdata", dwd[k], e_dwd[k]);
      chk("info_wren", iwren[k], e_iwr[k]);
      chk("info_wdata", iwd[k], e_iwd[k]);
      chk("drop_cnt", dropc[k], m_drop[k]);
      chk("err_cnt", errc[k], m_err[k]);
      chk("dbg_msb", dbg[k][3], 1'b0);
      if (dwren[k]) begin dwr_n[k]++; last_dwd[k] = dwd[k]; end
      if (iwren[k]) begin iwr_n[k]++; last_iwd[k] = iwd[k]; end
    end
  end

  task automatic rand_afull(input int k);
    dafull[k] = ($urandom % 6) == 0;
    iafull[k] = ($urandom % 10) == 0;
  endtask

  // Present one beat and hold it until the model reports it accepted
  task automatic drive_beat(input int k, input logic [7:0] kp, input logic l, input logic u);
    int t = 0;
    tdata[k] = {$urandom, $urandom}; tkeep[k] = kp; tlast[k] = l; tuser[k] = u; tvalid[k] = 1'b1;
    if (rand_af) rand_afull(k);
    forever begin
      @(posedge rx_clk);
      @(negedge rx_clk);
      if (acc_seen[k]) break;
      if (rand_af) rand_afull(k);
      t++;
      if (t > 200) begin chk("accept_timeout", 32'(t), 32'd0); break; end
    end
    tvalid[k] = 1'b0;
  endtask

  task automatic drive_frame(input int k, input int n, input logic [7:0] last_keep,
                             input logic u, input int af_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (i == af_at) dafull[k] = 1'b1;
      drive_beat(k, (i == n - 1) ? last_keep : 8'hFF, i == n - 1, (i == n - 1) ? u : 1'($urandom));
      if (gaps) begin
        repeat ($urandom % 3) begin
          if (rand_af) rand_afull(k);
          @(negedge rx_clk);
        end
      end
    end
  endtask

  initial begin
    int d0, i0, stalls;
    for (int k = 0; k < 2; k++) begin
      tdata[k] = '0; tkeep[k] = '0; tlast[k] = 1'b0; tuser[k] = 1'b0; tvalid[k] = 1'b0;
      dafull[k] = 1'b0; iafull[k] = 1'b0; dwr_n[k] = 0; iwr_n[k] = 0;
    end
    repeat (3) @(negedge rx_clk);
    rx_reset = 1'b0;
    @(negedge rx_clk);

    // Resync after reset, including a reset landing mid-frame
    drive_frame(0, 1, 8'hFF, 1'b0, -1, 1'b0);
    drive_beat(0, 8'hFF, 1'b0, 1'b0);
    drive_beat(0, 8'hFF, 1'b0, 1'b0);
    rx_reset = 1'b1;
    repeat (2) @(negedge rx_clk);
    rx_reset = 1'b0;
    d0 = dwr_n[0]; i0 = iwr_n[0];
    drive_frame(0, 3, 8'hFF, 1'b0, -1, 1'b0);
    chk("t1_discard_data", 32'(dwr_n[0] - d0), 32'd0);
    chk("t1_discard_info", 32'(iwr_n[0] - i0), 32'd0);
    d0 = dwr_n[0];
    drive_frame(0, 8, 8'hFF, 1'b0, -1, 1'b0);
    chk("t1_data_writes", 32'(dwr_n[0] - d0), 32'd8);
    chk("t1_info", last_iwd[0], {16'd64, 8'h00});

    // Whole-frame drop when afull at the first beat
    d0 = dwr_n[0]; i0 = iwr_n[0];
    drive_frame(0, 3, 8'hFF, 1'b0, 0, 1'b0);
    dafull[0] = 1'b0;
    chk("t2_no_data", 32'(dwr_n[0] - d0), 32'd0);
    chk("t2_no_info", 32'(iwr_n[0] - i0), 32'd0);
    chk("t2_drop_cnt", dropc[0], 32'd1);
    d0 = dwr_n[0];
    drive_frame(0, 8, 8'hFF, 1'b0, -1, 1'b1);
    chk("t2_next_frame", 32'(dwr_n[0] - d0), 32'd8);

    // Truncation when data afull rises mid-frame
    d0 = dwr_n[0];
    drive_frame(0, 10, 8'hFF, 1'b0, 2, 1'b0);
    dafull[0] = 1'b0;
    chk("t3_data_writes", 32'(dwr_n[0] - d0), 32'd3);
    chk("t3_forced_tlast", last_dwd[0][72], 1'b1);
    chk("t3_info", last_iwd[0], {16'd24, 8'h02});
    chk("t3_err_cnt", errc[0], 32'd1);

    // Single short bad frame
    d0 = dwr_n[0];
    drive_frame(0, 1, 8'h0F, 1'b1, -1, 1'b0);
    chk("t4_data_writes", 32'(dwr_n[0] - d0), 32'd1);
    chk("t4_keep", last_dwd[0][71:64], 8'h0F);
    chk("t4_info", last_iwd[0], {16'd4, 8'h09});

    // Oversize truncation at 128 bytes
    d0 = dwr_n[0];
    drive_frame(0, 20, 8'hFF, 1'b0, -1, 1'b1);
    chk("t5_data_writes", 32'(dwr_n[0] - d0), 32'd17);
    chk("t5_forced_tlast", last_dwd[0][72], 1'b1);
    chk("t5_info", last_iwd[0], {16'd136, 8'h04});
    d0 = dwr_n[0];
    drive_frame(0, 8, 8'hFF, 1'b0, -1, 1'b0);
    chk("t5_back_to_idle", 32'(dwr_n[0] - d0), 32'd8);

    // Backpressure instance stalls instead of dropping
    drive_frame(1, 1, 8'hFF, 1'b0, -1, 1'b0);
    dafull[1] = 1'b1;
    tdata[1] = '0; tkeep[1] = 8'hFF; tlast[1] = 1'b0; tuser[1] = 1'b0; tvalid[1] = 1'b1;
    stalls = 0;
    repeat (5) begin
      #1;
      if (!tready[1]) stalls++;
      @(negedge rx_clk);
    end
    dafull[1] = 1'b0;
    chk("t6_stall_cycles", 32'(stalls), 32'd5);
    d0 = dwr_n[1];
    drive_frame(1, 8, 8'hFF, 1'b0, -1, 1'b0);
    chk("t6_data_writes", 32'(dwr_n[1] - d0), 32'd8);
    chk("t6_info", last_iwd[1], {16'd64, 8'h00});
    chk("t6_drop_cnt", dropc[1], 32'd0);

    // Random traffic with random almost-full on both instances
    rand_af = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 2; k++) begin
        drive_frame(k, 1 + int'($urandom % 24), 8'hFF >> ($urandom % 8), 1'($urandom), -1, 1'b1);
      end
    end
    rand_af = 1'b0;
    for (int k = 0; k < 2; k++) begin dafull[k] = 1'b0; iafull[k] = 1'b0; end
    repeat (4) @(negedge rx_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifm_rx_ingress.md
Name: ifm_rx_ingress

Overview:
- Parametrised MAC-receive ingress stage for the 10GbE RX path. Sits between the MAC AXI-Stream master and the data and info FIFOs.
- Writes whole frames into the data FIFO and one status/length word per frame into the info FIFO.
- Overflow is handled either by frame drop/truncation or by AXI backpressure, selected by parameter.
- Adds resynchronisation after reset, oversize/runt detection, byte counting and drop/error statistics.

Parameters:
- C_DATA_WIDTH, 64, stream data width in bits (64 or 128).
- C_KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width.
- C_LEN_WIDTH, 16, frame byte-count width; the count saturates at all-ones.
- C_MAX_FRAME, 9216, maximum accepted frame length in bytes.
- C_MIN_FRAME, 64, frames shorter than this are flagged as runt.
- C_BACKPRESSURE, 0, overflow mode: 0 = drop/truncate with tready tied high; 1 = deassert tready.

Ports:
- rx_clk  in  1  clock
- rx_reset  in  1  reset
- rx_axis_mac_tdata  in  C_DATA_WIDTH  frame data
- rx_axis_mac_tkeep  in  C_KEEP_WIDTH  byte enables, contiguous from bit 0
- rx_axis_mac_tlast  in  1  end of frame
- rx_axis_mac_tuser  in  1  MAC bad-frame flag, valid on tlast
- rx_axis_mac_tvalid  in  1  beat valid
- rx_axis_mac_tready  out  1  beat ready
- data_fifo_wdata  out  C_DATA_WIDTH+C_KEEP_WIDTH+1  {tlast, tkeep, tdata}
- data_fifo_wren  out  1  data write strobe
- data_fifo_afull  in  1  data FIFO almost full
- info_fifo_wdata  out  C_LEN_WIDTH+8  {len, status[7:0]}
- info_fifo_wren  out  1  info write strobe
- info_fifo_afull  in  1  info FIFO almost full
- drop_cnt  out  32  count of frames dropped whole
- err_cnt  out  32  count of info words with nonzero status
- ifm_in_fsm_dbg  out  4  {1'b0, state[2:0]}

Behaviour:
- Reset is on rx_reset, asynchronous, active-high; clock is rx_clk.
- Reset values: state = S_SYNC; every output register = 0, including both wren strobes, both wdata buses and both counters.
- rx_axis_mac_tready: in C_BACKPRESSURE=1 mode it is 0 when afull applies (see below). In C_BACKPRESSURE=0 mode it is constantly 1, including during reset.
- Beat accept: acc = tvalid & tready.
- Latency: outputs are registered. Each write appears 1 cycle after its accepted beat, and data_fifo_wdata is the registered copy of that beat. A frame's info write is in the same cycle as its last data write.
- afull: data_fifo_afull OR info_fifo_afull.
- bytes: popcount(tkeep). len_next = len + bytes, saturating.
- States:
  - S_SYNC: discard every accepted beat. On acc & tlast go to S_IDLE. This guarantees no partial frame after reset, including reset mid-frame.
  - S_IDLE: on acc, len_next = bytes.
    - If afull and C_BACKPRESSURE=0: do not write; drop_cnt++. Go to S_DROP, or stay in S_IDLE if tlast.
    - Otherwise: write the beat. Go to S_PASS, or finish the frame (write info) and stay in S_IDLE if tlast.
    - In C_BACKPRESSURE=1 mode, tready = ~afull in this state.
  - S_PASS: on acc, write the beat and update len.
    - If tlast: write info, go to S_IDLE.
    - Else if len_next > C_MAX_FRAME: write the beat with its tlast bit forced to 1, write info with oversize set, go to S_TRUNC.
    - Else if data_fifo_afull and C_BACKPRESSURE=0: same forced-tlast handling, but with the truncated flag set, go to S_TRUNC.
    - In C_BACKPRESSURE=1 mode, tready = ~data_fifo_afull in this state, and truncation happens on oversize only.
  - S_DROP, S_TRUNC: discard beats. On acc & tlast go to S_IDLE. tready = 1 in both.
- Status byte:
  - [0] tuser of the final written beat (0 if truncated)
  - [1] truncated on afull
  - [2] oversize
  - [3] runt (final len < C_MIN_FRAME)
  - [7:4] = 0
- Counters: 32-bit and saturating. err_cnt increments on each info write with status != 0. drop_cnt increments once per dropped frame, on its first beat.
- Simultaneous events: tlast on the beat that also exceeds C_MAX_FRAME gives a normal end-of-frame with oversize set, then S_IDLE (not S_TRUNC). Oversize takes priority over afull truncation.
- Gaps: tvalid gaps within a frame are legal, and state is held across them.

Test Plan:
1. Reset asserted mid-frame, then the remaining 3 beats with tlast, then a 64-byte frame (8 beats, tkeep=FF) -> no writes for the 3 beats; 8 data writes; info len=64, status=0x00.
2. data_fifo_afull=1 at the first beat of a 3-beat frame, C_BACKPRESSURE=0 -> no wren of either kind; drop_cnt=1; the next frame is written normally.
3. afull rises before beat 3 of a 10-beat frame -> 3 data writes, the 3rd with bit[72]=1; info len=24, status=0x02; beats 4-10 discarded; err_cnt=1.
4. Single-beat frame, tkeep=0x0F, tuser=1 -> 1 data write, wdata[71:64]=0x0F; info len=4, status=0x09.
5. C_MAX_FRAME=128, 20-beat frame -> 17 data writes, the 17th with tlast forced; info len=136, status=0x04; return to S_IDLE after beat 20.
6. C_BACKPRESSURE=1, afull=1 for 5 cycles at frame start -> tready=0 for those 5 cycles; frame written intact once afull falls; drop_cnt=0.
